// File: rtl/generador_sync_vga.sv
// generador_sync_vga: horizontal timing engine and sync decoder for the VGA path.
// Divides Clk into a pixel tick, runs the horizontal count and phase FSM, and
// emits fin_linea / inicio_cuadro plus registered hsync, vsync and video_on.
// Optional macro VGA_SYNC_ACTIVE_HIGH_EN: when defined, hsync/vsync are active-high
// (inactive 0); when undefined (default), they are active-low (inactive 1).
module generador_sync_vga #(
   parameter int unsigned DIV       = 2,
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33
) (
   input  logic       Clk,
   input  logic       reset,
   input  logic [9:0] cuenta_v,
   output logic       tick_pixel,
   output logic [9:0] cuenta_h,
   output logic       fin_linea,
   output logic       inicio_cuadro,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on
);

   localparam int unsigned CW      = 10;
   localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int unsigned PW      = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [CW-1:0] H_VIS_LAST  = CW'(H_VISIBLE - 1);
   localparam logic [CW-1:0] H_FP_LAST   = CW'(H_VISIBLE + H_FP - 1);
   localparam logic [CW-1:0] H_SYNC_LAST = CW'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam logic [CW-1:0] H_LAST      = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST      = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] V_VIS_END   = CW'(V_VISIBLE);
   localparam logic [CW-1:0] V_SYNC_INI  = CW'(V_VISIBLE + V_FP);
   localparam logic [CW-1:0] V_SYNC_FIN  = CW'(V_VISIBLE + V_FP + V_SYNC);
   localparam logic [PW-1:0] PRES_LAST   = PW'(DIV - 1);

`ifdef VGA_SYNC_ACTIVE_HIGH_EN
   localparam logic SYNC_ON  = 1'b1;
   localparam logic SYNC_OFF = 1'b0;
`else
   localparam logic SYNC_ON  = 1'b0;
   localparam logic SYNC_OFF = 1'b1;
`endif

   typedef enum logic [1:0] {
      VISIBLE = 2'd0,
      FRONT   = 2'd1,
      SYNC    = 2'd2,
      BACK    = 2'd3
   } fase_t;

   fase_t         fase;
   fase_t         fase_sig;
   logic [PW-1:0] pres;
   logic [CW-1:0] cuenta_h_sig;

   // Prescaler; tick_pixel is the registered terminal-count flag, so the first
   // tick lands DIV clocks after reset is released.
   always_ff @(posedge Clk) begin
      if (reset) begin
         pres       <= '0;
         tick_pixel <= 1'b0;
      end else begin
         tick_pixel <= (pres == PRES_LAST);
         pres       <= (pres == PRES_LAST) ? '0 : pres + PW'(1);
      end
   end

   // Phase state register.
   always_ff @(posedge Clk) begin
      if (reset) begin
         fase <= VISIBLE;
      end else begin
         fase <= fase_sig;
      end
   end

   // Next phase, next horizontal count and end-of-line/frame pulses.
   always_comb begin
      fase_sig      = fase;
      cuenta_h_sig  = cuenta_h;
      fin_linea     = 1'b0;
      inicio_cuadro = 1'b0;
      if (tick_pixel) begin
         cuenta_h_sig = (cuenta_h == H_LAST) ? '0 : cuenta_h + CW'(1);
         unique case (fase)
            VISIBLE: if (cuenta_h == H_VIS_LAST)  fase_sig = FRONT;
            FRONT:   if (cuenta_h == H_FP_LAST)   fase_sig = SYNC;
            SYNC:    if (cuenta_h == H_SYNC_LAST) fase_sig = BACK;
            BACK:    if (cuenta_h == H_LAST)      fase_sig = VISIBLE;
            default: fase_sig = VISIBLE;
         endcase
         fin_linea     = (cuenta_h == H_LAST);
         inicio_cuadro = (cuenta_h == H_LAST) && (cuenta_v == V_LAST);
      end
   end

   // Horizontal counter and registered sync/blanking decode (one Clk lag).
   always_ff @(posedge Clk) begin
      if (reset) begin
         cuenta_h <= '0;
         hsync    <= SYNC_OFF;
         vsync    <= SYNC_OFF;
         video_on <= 1'b0;
      end else begin
         cuenta_h <= cuenta_h_sig;
         hsync    <= (fase == SYNC) ? SYNC_ON : SYNC_OFF;
         vsync    <= ((cuenta_v >= V_SYNC_INI) && (cuenta_v < V_SYNC_FIN)) ? SYNC_ON : SYNC_OFF;
         video_on <= (fase == VISIBLE) && (cuenta_v < V_VIS_END);
      end
   end

endmodule

// File: tb/tb_generador_sync_vga.sv
// Self-checking bench for generador_sync_vga: DIV=2 and DIV=1 instances share
// stimulus; a per-cycle analytic model feeds a scoreboard queue, and a vector
// table checks per-line totals for each cuenta_v value.
module tb_generador_sync_vga;

`ifdef VGA_SYNC_ACTIVE_HIGH_EN
   localparam logic SON = 1'b1;
`else
   localparam logic SON = 1'b0;
`endif
   localparam logic SOFF = !SON;

   logic       Clk = 1'b0;
   logic       reset;
   logic [9:0] cuenta_v;

   logic       t2, fin2, ini2, hs2, vs2, vid2;
   logic [9:0] ch2;
   logic       t1, fin1, ini1, hs1, vs1, vid1;
   logic [9:0] ch1;

   generador_sync_vga #(.DIV(2)) dut (
      .Clk(Clk), .reset(reset), .cuenta_v(cuenta_v),
      .tick_pixel(t2), .cuenta_h(ch2), .fin_linea(fin2), .inicio_cuadro(ini2),
      .hsync(hs2), .vsync(vs2), .video_on(vid2)
   );

   generador_sync_vga #(.DIV(1)) dut1 (
      .Clk(Clk), .reset(reset), .cuenta_v(cuenta_v),
      .tick_pixel(t1), .cuenta_h(ch1), .fin_linea(fin1), .inicio_cuadro(ini1),
      .hsync(hs1), .vsync(vs1), .video_on(vid1)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic       tick;
      logic [9:0] ch;
      logic       fin;
      logic       ini;
      logic       hs;
      logic       vs;
      logic       vid;
   } obs_t;

   typedef struct {
      logic [9:0] cv;
      int hs; int vs; int vid;
      int fin2; int fin1; int ini2; int ini1; int run1;
   } vec_t;

   obs_t q2[$];
   obs_t q1[$];
   vec_t vecs[12];

   int n;
   int checks;
   int errors;
   int first_t2, first_t1;
   int c_hs2, c_hs1, c_vs2, c_vs1, c_vid2, c_vid1;
   int c_fin2, c_fin1, c_ini2, c_ini1, run1, maxrun1;

   // Horizontal count after n edges since release (n=0: reset state).
   function automatic int ch_at(input int div, input int k);
      if (k <= 0) return 0;
      return ((k - 1) / div) % 800;
   endfunction

   // Expected outputs after edge n with cuenta_v = cv sampled at that edge.
   function automatic obs_t model(input int div, input int k, input logic [9:0] cv);
      obs_t e;
      int c;
      int p;
      e.tick = 1'b0; e.ch = '0; e.fin = 1'b0; e.ini = 1'b0;
      e.hs = SOFF; e.vs = SOFF; e.vid = 1'b0;
      if (k > 0) begin
         c      = ch_at(div, k);
         p      = ch_at(div, k - 1);
         e.tick = ((k % div) == 0);
         e.ch   = 10'(c);
         e.fin  = e.tick && (c == 799);
         e.ini  = e.fin && (cv == 10'd524);
         e.hs   = (p >= 656 && p < 752) ? SON : SOFF;
         e.vs   = (cv >= 10'd490 && cv < 10'd492) ? SON : SOFF;
         e.vid  = (p < 640) && (cv < 10'd480);
      end
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // One clock: drive inputs, queue expectations, sample at negedge, compare.
   task automatic step(input logic r, input logic [9:0] cv);
      obs_t a2, a1, e2, e1;
      reset    = r;
      cuenta_v = cv;
      n = r ? 0 : n + 1;
      q2.push_back(model(2, n, cv));
      q1.push_back(model(1, n, cv));
      @(posedge Clk);
      @(negedge Clk);
      a2 = {t2, ch2, fin2, ini2, hs2, vs2, vid2};
      a1 = {t1, ch1, fin1, ini1, hs1, vs1, vid1};
      e2 = q2.pop_front();
      e1 = q1.pop_front();
      check($sformatf("cycle n=%0d div2 outputs", n), 32'(a2), 32'(e2));
      check($sformatf("cycle n=%0d div1 outputs", n), 32'(a1), 32'(e1));
      if (hs2 === SON) c_hs2++;
      if (hs1 === SON) c_hs1++;
      if (vs2 === SON) c_vs2++;
      if (vs1 === SON) c_vs1++;
      if (vid2 === 1'b1) c_vid2++;
      if (vid1 === 1'b1) c_vid1++;
      if (fin2 === 1'b1) c_fin2++;
      if (fin1 === 1'b1) c_fin1++;
      if (ini2 === 1'b1) c_ini2++;
      if (ini1 === 1'b1) c_ini1++;
      if (vid1 === 1'b1) begin
         run1++;
         if (run1 > maxrun1) maxrun1 = run1;
      end else begin
         run1 = 0;
      end
      if (!r && t2 === 1'b1 && first_t2 < 0) first_t2 = n;
      if (!r && t1 === 1'b1 && first_t1 < 0) first_t1 = n;
   endtask

   task automatic clear_counts();
      c_hs2 = 0; c_hs1 = 0; c_vs2 = 0; c_vs1 = 0; c_vid2 = 0; c_vid1 = 0;
      c_fin2 = 0; c_fin1 = 0; c_ini2 = 0; c_ini1 = 0; run1 = 0; maxrun1 = 0;
   endtask

   initial begin
      checks = 0; errors = 0; n = 0;
      first_t2 = -1; first_t1 = -1;
      clear_counts();
      reset = 1'b1;
      cuenta_v = '0;

      //          cv      hs   vs    vid   f2 f1 i2 i1 run1
      vecs[0]  = '{10'd0,   192, 0,    1280, 1, 2, 0, 0, 640};
      vecs[1]  = '{10'd100, 192, 0,    1280, 1, 2, 0, 0, 640};
      vecs[2]  = '{10'd479, 192, 0,    1280, 1, 2, 0, 0, 640};
      vecs[3]  = '{10'd480, 192, 0,    0,    1, 2, 0, 0, 0};
      vecs[4]  = '{10'd489, 192, 0,    0,    1, 2, 0, 0, 0};
      vecs[5]  = '{10'd490, 192, 1600, 0,    1, 2, 0, 0, 0};
      vecs[6]  = '{10'd491, 192, 1600, 0,    1, 2, 0, 0, 0};
      vecs[7]  = '{10'd492, 192, 0,    0,    1, 2, 0, 0, 0};
      vecs[8]  = '{10'd524, 192, 0,    0,    1, 2, 1, 2, 0};
      vecs[9]  = '{10'd0,   192, 0,    1280, 1, 2, 0, 0, 640};
      vecs[10] = '{10'd600, 192, 0,    0,    1, 2, 0, 0, 0};
      vecs[11] = '{10'd1023,192, 0,    0,    1, 2, 0, 0, 0};

      @(negedge Clk);
      repeat (5) step(1'b1, 10'd0);
      check("reset cuenta_h", 32'(ch2), 32'd0);
      check("reset tick_pixel", 32'(t2), 32'd0);
      check("reset hsync", 32'(hs2), 32'(SOFF));
      check("reset vsync", 32'(vs2), 32'(SOFF));
      check("reset video_on", 32'(vid2), 32'd0);
      check("reset tick_pixel div1", 32'(t1), 32'd0);

      repeat (4) step(1'b0, 10'd0);
      check("first tick div2", 32'(first_t2), 32'd2);
      check("first tick div1", 32'(first_t1), 32'd1);

      for (int i = 0; i < 12; i++) begin
         clear_counts();
         repeat (1600) step(1'b0, vecs[i].cv);
         check($sformatf("v=%0d hsync count div2", vecs[i].cv), 32'(c_hs2), 32'(vecs[i].hs));
         check($sformatf("v=%0d hsync count div1", vecs[i].cv), 32'(c_hs1), 32'(vecs[i].hs));
         check($sformatf("v=%0d vsync count div2", vecs[i].cv), 32'(c_vs2), 32'(vecs[i].vs));
         check($sformatf("v=%0d vsync count div1", vecs[i].cv), 32'(c_vs1), 32'(vecs[i].vs));
         check($sformatf("v=%0d video_on count div2", vecs[i].cv), 32'(c_vid2), 32'(vecs[i].vid));
         check($sformatf("v=%0d video_on count div1", vecs[i].cv), 32'(c_vid1), 32'(vecs[i].vid));
         check($sformatf("v=%0d fin_linea count div2", vecs[i].cv), 32'(c_fin2), 32'(vecs[i].fin2));
         check($sformatf("v=%0d fin_linea count div1", vecs[i].cv), 32'(c_fin1), 32'(vecs[i].fin1));
         check($sformatf("v=%0d inicio_cuadro count div2", vecs[i].cv), 32'(c_ini2), 32'(vecs[i].ini2));
         check($sformatf("v=%0d inicio_cuadro count div1", vecs[i].cv), 32'(c_ini1), 32'(vecs[i].ini1));
         check($sformatf("v=%0d video_on run div1", vecs[i].cv), 32'(maxrun1), 32'(vecs[i].run1));
      end

      // Reset asserted mid-line while the DIV=2 instance is in its sync phase.
      for (int k = 0; k < 1600 && ch_at(2, n) != 700; k++) step(1'b0, 10'd0);
      check("pre-reset cuenta_h", 32'(ch2), 32'd700);
      check("pre-reset hsync active", 32'(hs2), 32'(SON));
      clear_counts();
      step(1'b1, 10'd0);
      check("mid-line reset cuenta_h", 32'(ch2), 32'd0);
      check("mid-line reset hsync", 32'(hs2), 32'(SOFF));
      check("mid-line reset fin_linea", 32'(fin2), 32'd0);
      check("mid-line reset tick_pixel", 32'(t2), 32'd0);
      check("mid-line reset video_on", 32'(vid2), 32'd0);
      check("mid-line reset no fin pulse", 32'(c_fin2 + c_fin1), 32'd0);

      first_t2 = -1; first_t1 = -1;
      repeat (6) step(1'b0, 10'd0);
      check("first tick div2 after mid-line reset", 32'(first_t2), 32'd2);
      check("first tick div1 after mid-line reset", 32'(first_t1), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
